// File: rtl/nanosoc_input_stage_if.sv
// rtl/nanosoc_input_stage_if.sv - bus bundle between one AHB master port and its input stage
interface nanosoc_input_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  accept_dec;
    logic                  readyout_dec;
    logic                  resp_dec;
    logic                  trans_valid;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic [1:0]            HTRANSM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [3:0]            HPROTM;
    logic                  HMASTLOCKM;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
               HREADYS, accept_dec, readyout_dec, resp_dec,
        output trans_valid, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
               HMASTLOCKM, HREADYOUTS, HRESPS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
               HREADYS, accept_dec, readyout_dec, resp_dec,
        input  trans_valid, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
               HMASTLOCKM, HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/nanosoc_input_stage.sv
// rtl/nanosoc_input_stage.sv - bus matrix input stage: holds a stalled address phase and tracks its data phase
module nanosoc_input_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    nanosoc_input_stage_if.slave    bus
);

    logic                  pend_q, pend_d;
    logic                  data_phase_q, data_phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            trans_q, trans_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [2:0]            burst_q, burst_d;
    logic [3:0]            prot_q, prot_d;
    logic                  mastlock_q, mastlock_d;

    logic new_valid;
    logic trans_valid;

    assign new_valid   = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    assign trans_valid = pend_q | new_valid;

    always_comb begin
        pend_d       = pend_q;
        data_phase_d = data_phase_q;
        addr_d       = addr_q;
        trans_d      = trans_q;
        write_d      = write_q;
        size_d       = size_q;
        burst_d      = burst_q;
        prot_d       = prot_q;
        mastlock_d   = mastlock_q;

        // A new request seen while holding cannot be legal (master is stalled), so it is dropped.
        if (pend_q) begin
            pend_d = ~bus.accept_dec;
        end else begin
            pend_d = new_valid & ~bus.accept_dec;
        end

        if (new_valid && !pend_q) begin
            addr_d     = bus.HADDRS;
            trans_d    = bus.HTRANSS;
            write_d    = bus.HWRITES;
            size_d     = bus.HSIZES;
            burst_d    = bus.HBURSTS;
            prot_d     = bus.HPROTS;
            mastlock_d = bus.HMASTLOCKS;
        end

        if (trans_valid && bus.accept_dec) begin
            data_phase_d = 1'b1;
        end else if (bus.readyout_dec) begin
            data_phase_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q       <= 1'b0;
            data_phase_q <= 1'b0;
            addr_q       <= '0;
            trans_q      <= 2'b00;
            write_q      <= 1'b0;
            size_q       <= 3'b000;
            burst_q      <= 3'b000;
            prot_q       <= 4'b0000;
            mastlock_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            data_phase_q <= data_phase_d;
            addr_q       <= addr_d;
            trans_q      <= trans_d;
            write_q      <= write_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            prot_q       <= prot_d;
            mastlock_q   <= mastlock_d;
        end
    end

    assign bus.trans_valid = trans_valid;
    assign bus.HADDRM      = pend_q ? addr_q     : bus.HADDRS;
    assign bus.HWRITEM     = pend_q ? write_q    : bus.HWRITES;
    assign bus.HSIZEM      = pend_q ? size_q     : bus.HSIZES;
    assign bus.HBURSTM     = pend_q ? burst_q    : bus.HBURSTS;
    assign bus.HPROTM      = pend_q ? prot_q     : bus.HPROTS;
    assign bus.HMASTLOCKM  = pend_q ? mastlock_q : bus.HMASTLOCKS;
    // Downstream must only see a non-IDLE transfer when a request is actually being made.
    assign bus.HTRANSM     = !trans_valid ? 2'b00 : (pend_q ? trans_q : bus.HTRANSS);

    assign bus.HREADYOUTS  = pend_q ? 1'b0 : (data_phase_q ? bus.readyout_dec : 1'b1);
    assign bus.HRESPS      = (data_phase_q && !pend_q) ? bus.resp_dec : 1'b0;

endmodule

// File: tb/tb_nanosoc_input_stage.sv
// tb/tb_nanosoc_input_stage.sv - directed self-checking bench for nanosoc_input_stage
module tb_nanosoc_input_stage;

    logic HCLK;
    logic HRESETn;
    int   n_checks;
    int   n_fail;

    nanosoc_input_stage_if #(.ADDR_WIDTH(32)) bus ();

    nanosoc_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.HSELS        = 1'b0;
        bus.HADDRS       = 32'h0;
        bus.HTRANSS      = 2'b00;
        bus.HWRITES      = 1'b0;
        bus.HSIZES       = 3'b010;
        bus.HBURSTS      = 3'b000;
        bus.HPROTS       = 4'b0011;
        bus.HMASTLOCKS   = 1'b0;
        bus.HREADYS      = 1'b1;
        bus.accept_dec   = 1'b0;
        bus.readyout_dec = 1'b1;
        bus.resp_dec     = 1'b0;
    endtask

    task automatic nonseq(input logic [31:0] addr, input logic acc);
        bus.HSELS      = 1'b1;
        bus.HTRANSS    = 2'b10;
        bus.HADDRS     = addr;
        bus.HREADYS    = 1'b1;
        bus.accept_dec = acc;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESETn = 1'b0;
        step();
        #2;
        n_checks++; if (bus.trans_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trans_valid got %b want 0", bus.trans_valid); end
        n_checks++; if (bus.HTRANSM !== 2'b00) begin n_fail++; $display("FAIL reset_htransm got %b want 00", bus.HTRANSM); end
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyouts got %b want 1", bus.HREADYOUTS); end
        n_checks++; if (bus.HRESPS !== 1'b0) begin n_fail++; $display("FAIL reset_hresps got %b want 0", bus.HRESPS); end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_unheld();
        nonseq(32'h2000_0010, 1'b1);
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.HADDRM !== 32'h2000_0010) begin n_fail++; $display("FAIL unheld_haddrm got %h want 20000010", bus.HADDRM); end
        n_checks++; if (bus.HTRANSM !== 2'b10) begin n_fail++; $display("FAIL unheld_htransm got %b want 10", bus.HTRANSM); end
        n_checks++; if (bus.trans_valid !== 1'b1) begin n_fail++; $display("FAIL unheld_trans_valid got %b want 1", bus.trans_valid); end
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL unheld_addr_ready got %b want 1", bus.HREADYOUTS); end
        step();
        idle_inputs();
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL unheld_dp_wait got %b want 0", bus.HREADYOUTS); end
        bus.readyout_dec = 1'b1;
        #1;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL unheld_dp_ready got %b want 1", bus.HREADYOUTS); end
        step();
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL unheld_dp_done got %b want 1", bus.HREADYOUTS); end
        bus.readyout_dec = 1'b1;
    endtask

    task automatic test_hold_replay();
        nonseq(32'h2000_0040, 1'b0);
        bus.HWRITES = 1'b1;
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL hold_capture_ready got %b want 1", bus.HREADYOUTS); end
        step();
        for (int c = 1; c <= 3; c++) begin
            bus.HADDRS     = 32'h5555_0000 + 32'(c);
            bus.HWRITES    = 1'b0;
            bus.accept_dec = (c == 3);
            #2;
            n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL hold_stall[%0d] got %b want 0", c, bus.HREADYOUTS); end
            n_checks++; if (bus.HADDRM !== 32'h2000_0040) begin n_fail++; $display("FAIL hold_haddrm[%0d] got %h want 20000040", c, bus.HADDRM); end
            n_checks++; if (bus.HWRITEM !== 1'b1) begin n_fail++; $display("FAIL hold_hwritem[%0d] got %b want 1", c, bus.HWRITEM); end
            n_checks++; if (bus.HTRANSM !== 2'b10) begin n_fail++; $display("FAIL hold_htransm[%0d] got %b want 10", c, bus.HTRANSM); end
            step();
        end
        idle_inputs();
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.trans_valid !== 1'b0) begin n_fail++; $display("FAIL hold_released got %b want 0", bus.trans_valid); end
        n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL hold_dp_wait got %b want 0", bus.HREADYOUTS); end
        bus.readyout_dec = 1'b1;
        #1;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL hold_dp_ready got %b want 1", bus.HREADYOUTS); end
        step();
    endtask

    task automatic test_idle();
        idle_inputs();
        bus.HSELS      = 1'b1;
        bus.HTRANSS    = 2'b00;
        bus.accept_dec = 1'b1;
        #2;
        n_checks++; if (bus.trans_valid !== 1'b0) begin n_fail++; $display("FAIL idle_trans_valid got %b want 0", bus.trans_valid); end
        n_checks++; if (bus.HTRANSM !== 2'b00) begin n_fail++; $display("FAIL idle_htransm got %b want 00", bus.HTRANSM); end
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", bus.HREADYOUTS); end
        step();
        bus.HTRANSS      = 2'b01;
        bus.accept_dec   = 1'b0;
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL idle_no_dp got %b want 1", bus.HREADYOUTS); end
        n_checks++; if (bus.HTRANSM !== 2'b00) begin n_fail++; $display("FAIL busy_htransm got %b want 00", bus.HTRANSM); end
        step();
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL busy_no_hold got %b want 1", bus.HREADYOUTS); end
        idle_inputs();
    endtask

    task automatic test_error();
        nonseq(32'h2000_0080, 1'b1);
        step();
        idle_inputs();
        bus.readyout_dec = 1'b0;
        bus.resp_dec     = 1'b1;
        #2;
        n_checks++; if (bus.HRESPS !== 1'b1) begin n_fail++; $display("FAIL err_resp1 got %b want 1", bus.HRESPS); end
        n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL err_ready1 got %b want 0", bus.HREADYOUTS); end
        step();
        bus.readyout_dec = 1'b1;
        #2;
        n_checks++; if (bus.HRESPS !== 1'b1) begin n_fail++; $display("FAIL err_resp2 got %b want 1", bus.HRESPS); end
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL err_ready2 got %b want 1", bus.HREADYOUTS); end
        step();
        #2;
        n_checks++; if (bus.HRESPS !== 1'b0) begin n_fail++; $display("FAIL err_resp_done got %b want 0", bus.HRESPS); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        nonseq(32'h2000_0100, 1'b1);
        step();
        nonseq(32'h2000_0104, 1'b1);
        bus.readyout_dec = 1'b1;
        #2;
        n_checks++; if (bus.HADDRM !== 32'h2000_0104) begin n_fail++; $display("FAIL b2b_haddrm got %h want 20000104", bus.HADDRM); end
        step();
        idle_inputs();
        bus.readyout_dec = 1'b0;
        #2;
        n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL b2b_dp_kept got %b want 0", bus.HREADYOUTS); end
        bus.readyout_dec = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        nonseq(32'h2000_0200, 1'b0);
        step();
        idle_inputs();
        bus.accept_dec = 1'b0;
        #1;
        n_checks++; if (bus.HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL rmh_stalled got %b want 0", bus.HREADYOUTS); end
        HRESETn = 1'b0;
        #1;
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL rmh_ready got %b want 1", bus.HREADYOUTS); end
        n_checks++; if (bus.trans_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_trans_valid got %b want 0", bus.trans_valid); end
        step();
        HRESETn = 1'b1;
        step();
        #2;
        n_checks++; if (bus.trans_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_after_tv got %b want 0", bus.trans_valid); end
        n_checks++; if (bus.HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL rmh_after_ready got %b want 1", bus.HREADYOUTS); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        HRESETn  = 1'b0;
        idle_inputs();
        test_reset();
        test_unheld();
        test_hold_replay();
        test_idle();
        test_error();
        test_back_to_back();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
